// File: rtl/gpio_tx_pkg.sv
// rtl/gpio_tx_pkg.sv - shared state encoding and counter sizing for the GPIO burst sender
package gpio_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      WAIT,
      LOAD,
      STROBE,
      END,
      ABORT,
      GAP
   } tx_state_e;

   // Bits needed to hold values 0..max_val; never less than one bit.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/gpio_burst_tx_if.sv
// rtl/gpio_burst_tx_if.sv - upstream FIFO, host GPIO and status signals of the burst sender
interface gpio_burst_tx_if #(
   parameter int DW    = 8,
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic [DW-1:0]    s_data;
   logic             s_valid;
   logic             s_ready;
   logic             ack;
   logic             clk_out;
   logic [DW-1:0]    data_out;
   logic             data_oe;
   logic             busy;
   logic             done;
   logic             timeout;

   modport master (
      output start, len, s_data, s_valid, ack,
      input  s_ready, clk_out, data_out, data_oe, busy, done, timeout
   );

   modport slave (
      input  start, len, s_data, s_valid, ack,
      output s_ready, clk_out, data_out, data_oe, busy, done, timeout
   );
endinterface

// File: rtl/ack_toggle_sync.sv
// rtl/ack_toggle_sync.sv - two-flop synchroniser for the host ack toggle plus event reference
module ack_toggle_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ack_i,
   input  logic load_ref_i,
   input  logic consume_i,
   output logic ack_evt_o
);
   logic s1_q, s2_q;
   logic ref_q, ref_d;

   always_comb begin
      ref_d = ref_q;
      if (load_ref_i || consume_i) begin
         ref_d = s2_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         ref_q <= 1'b0;
      end else begin
         s1_q  <= ack_i;
         s2_q  <= s1_q;
         ref_q <= ref_d;
      end
   end

   assign ack_evt_o = (s2_q != ref_q);
endmodule

// File: rtl/gpio_burst_tx.sv
// rtl/gpio_burst_tx.sv - sends a length header then N FIFO words to the host, one clk_out toggle each
module gpio_burst_tx
   import gpio_tx_pkg::*;
#(
   parameter int DW      = 8,
   parameter int LEN_W   = 8,
   parameter int TO_CYC  = 1024,
   parameter int GAP_CYC = 2
) (
   input logic            clk_i,
   input logic            rst_i,
   gpio_burst_tx_if.slave bus
);
   localparam int TO_W = cnt_w(TO_CYC);
   localparam int GAP_W = cnt_w(GAP_CYC);
   localparam int MAXW = (DW > LEN_W) ? DW : LEN_W;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

   tx_state_e        state_q, state_d;
   logic             clk_out_q, clk_out_d;
   logic [DW-1:0]    data_out_q, data_out_d;
   logic             data_oe_q, data_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             load_ref, consume, ack_evt, s_ready;
   logic [MAXW-1:0]  len_ext;
   logic [DW-1:0]    hdr_word;

   ack_toggle_sync u_ack_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ack_i      (bus.ack),
      .load_ref_i (load_ref),
      .consume_i  (consume),
      .ack_evt_o  (ack_evt)
   );

   // Header word is the length zero-extended or truncated to the data bus.
   assign len_ext  = MAXW'(bus.len);
   assign hdr_word = len_ext[DW-1:0];

   always_comb begin
      state_d    = state_q;
      clk_out_d  = clk_out_q;
      data_out_d = data_out_q;
      data_oe_d  = data_oe_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      rem_d      = rem_q;
      to_cnt_d   = to_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      load_ref   = 1'b0;
      consume    = 1'b0;
      s_ready    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               rem_d      = bus.len;
               busy_d     = 1'b1;
               data_out_d = hdr_word;
               data_oe_d  = 1'b1;
               load_ref   = 1'b1;
               state_d    = HDR;
            end
         end
         HDR, STROBE: begin
            clk_out_d = ~clk_out_q;
            to_cnt_d  = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            // An ack landing on the expiry cycle still counts as an ack.
            if (ack_evt) begin
               consume = 1'b1;
               if (rem_q == '0) begin
                  data_oe_d = 1'b0;
                  done_d    = 1'b1;
                  state_d   = END;
               end else begin
                  state_d = LOAD;
               end
            end else if ((TO_CYC != 0) && (to_cnt_q == TO_LAST)) begin
               data_oe_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = ABORT;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (bus.s_valid) begin
               data_out_d = bus.s_data;
               rem_d      = rem_q - LEN_W'(1);
               state_d    = STROBE;
            end
         end
         END, ABORT: begin
            gap_cnt_d = GAP_W'(GAP_CYC);
            state_d   = GAP;
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               clk_out_d = 1'b0;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         clk_out_q  <= 1'b0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         rem_q      <= '0;
         to_cnt_q   <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         clk_out_q  <= clk_out_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         rem_q      <= rem_d;
         to_cnt_q   <= to_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign bus.s_ready  = s_ready;
   assign bus.clk_out  = clk_out_q;
   assign bus.data_out = data_out_q;
   assign bus.data_oe  = data_oe_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.timeout  = timeout_q;
endmodule
